// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, the
// next-PC selection encoding and the default widths and reset address.
package fetch_unit_pkg;

   localparam int              DEFAULT_ADDR_W    = 16;
   localparam int              DEFAULT_INST_W    = 18;
   localparam int              DEFAULT_RAS_DEPTH = 8;
   localparam logic [15:0]     DEFAULT_RESET_PC  = 16'h0000;

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } fetch_state_t;

   typedef enum logic [1:0] {
      NPC_KEEP = 2'd0,
      NPC_INC  = 2'd1,
      NPC_JUMP = 2'd2,
      NPC_RET  = 2'd3
   } next_pc_sel_t;

   // Decode may raise several next-PC bits at once; a return always wins,
   // then a jump/CALL, then a plain increment, otherwise the PC is kept.
   function automatic next_pc_sel_t next_pc_select(input logic ret,
                                                   input logic jump,
                                                   input logic pc_inc);
      if (ret)
         return NPC_RET;
      else if (jump)
         return NPC_JUMP;
      else if (pc_inc)
         return NPC_INC;
      else
         return NPC_KEEP;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage
// (master) and the instruction memory (slave).
interface fetch_unit_if #(
   parameter int ADDR_W = 16,
   parameter int INST_W = 18
);
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_req;
   logic              imem_ack;
   logic [INST_W-1:0] imem_data;

   modport master (
      output imem_addr,
      output imem_req,
      input  imem_ack,
      input  imem_data
   );

   modport slave (
      input  imem_addr,
      input  imem_req,
      output imem_ack,
      output imem_data
   );
endinterface

// File: rtl/fetch_unit_return_addr_stack.sv
// Circular return-address stack. A push into a full stack overwrites the
// oldest entry because the write pointer simply wraps; the count saturates.
module return_addr_stack #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] push_data,
   output logic [DATA_W-1:0] top,
   output logic              full,
   output logic              empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] entries [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  top_ptr;
   logic [CNT_W-1:0]  count;

   assign top_ptr = wr_ptr - PTR_W'(1);
   assign top     = entries[top_ptr];
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);

   // Storage needs no reset: an entry is only read once a push has filled it.
   always_ff @(posedge clk) begin
      if (push)
         entries[wr_ptr] <= push_data;
   end

   // Pointer and occupancy; a pop from an empty stack leaves both unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (push) begin
         wr_ptr <= wr_ptr + PTR_W'(1);
         if (!full)
            count <= count + CNT_W'(1);
      end else if (pop && !empty) begin
         wr_ptr <= top_ptr;
         count  <= count - CNT_W'(1);
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one instruction at a time
// over the imem handshake, holds it for decode and applies the next-PC
// decision (increment, jump/CALL, RET) when decode retires it.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int              ADDR_W    = DEFAULT_ADDR_W,
   parameter int              INST_W    = DEFAULT_INST_W,
   parameter int              RAS_DEPTH = DEFAULT_RAS_DEPTH,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst_n,
   fetch_unit_if.master      imem,
   output logic [INST_W-1:0] instruction,
   output logic              inst_valid,
   input  logic              inst_ready,
   input  logic              pc_inc,
   input  logic              jump,
   input  logic              ret,
   input  logic              call,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic [ADDR_W-1:0] pc,
   output logic              ras_overflow,
   output logic              ras_underflow
);
   fetch_state_t      state;
   next_pc_sel_t      npc_sel;
   logic              imem_req_q;
   logic              retire;
   logic [ADDR_W-1:0] pc_plus_one;
   logic              ras_push;
   logic              ras_pop;
   logic [ADDR_W-1:0] ras_top;
   logic              ras_full;
   logic              ras_empty;

   assign imem.imem_req  = imem_req_q;
   assign imem.imem_addr = pc;

   assign retire      = (state == HOLD) && inst_valid && inst_ready;
   assign npc_sel     = next_pc_select(ret, jump, pc_inc);
   assign pc_plus_one = pc + ADDR_W'(1);
   assign ras_push    = retire && (npc_sel == NPC_JUMP) && call;
   assign ras_pop     = retire && (npc_sel == NPC_RET) && !ras_empty;

   return_addr_stack #(
      .DEPTH  (RAS_DEPTH),
      .DATA_W (ADDR_W)
   ) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_plus_one),
      .top       (ras_top),
      .full      (ras_full),
      .empty     (ras_empty)
   );

   // Fetch/hold sequencer with registered request and valid. After reset the
   // request rises one cycle late, so an ack left over from before reset is
   // ignored; on retire the request rises in the same edge for back-to-back
   // fetches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= FETCH;
         pc            <= RESET_PC;
         imem_req_q    <= 1'b0;
         inst_valid    <= 1'b0;
         instruction   <= '0;
         ras_overflow  <= 1'b0;
         ras_underflow <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (!imem_req_q) begin
                  imem_req_q <= 1'b1;
               end else if (imem.imem_ack) begin
                  instruction <= imem.imem_data;
                  imem_req_q  <= 1'b0;
                  inst_valid  <= 1'b1;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (retire) begin
                  inst_valid <= 1'b0;
                  imem_req_q <= 1'b1;
                  state      <= FETCH;
                  case (npc_sel)
                     NPC_RET: begin
                        if (ras_empty) begin
                           pc            <= RESET_PC;
                           ras_underflow <= 1'b1;
                        end else begin
                           pc <= ras_top;
                        end
                     end
                     NPC_JUMP: begin
                        pc <= jump_addr;
                        if (call && ras_full)
                           ras_overflow <= 1'b1;
                     end
                     NPC_INC:  pc <= pc_plus_one;
                     default:  pc <= pc;
                  endcase
               end
            end
            default: state <= FETCH;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit: a latency-randomizing
// instruction memory plus a queue-based model of the PC and return stack.
module tb_fetch_unit;
   localparam int          RAS_DEPTH = 8;
   localparam logic [15:0] RESET_PC  = 16'h0000;

   logic        clk;
   logic        rst_n;
   logic [17:0] instruction;
   logic        inst_valid;
   logic        inst_ready;
   logic        pc_inc;
   logic        jump;
   logic        ret;
   logic        call;
   logic [15:0] jump_addr;
   logic [15:0] pc;
   logic        ras_overflow;
   logic        ras_underflow;

   fetch_unit_if #(.ADDR_W(16), .INST_W(18)) imem_bus ();

   fetch_unit #(
      .ADDR_W    (16),
      .INST_W    (18),
      .RAS_DEPTH (RAS_DEPTH),
      .RESET_PC  (RESET_PC)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem          (imem_bus),
      .instruction   (instruction),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .pc_inc        (pc_inc),
      .jump          (jump),
      .ret           (ret),
      .call          (call),
      .jump_addr     (jump_addr),
      .pc            (pc),
      .ras_overflow  (ras_overflow),
      .ras_underflow (ras_underflow)
   );

   int          num_compared   = 0;
   int          num_mismatched = 0;
   logic [17:0] mem [65536];
   int          lat_min = 0;
   int          lat_max = 0;

   logic [15:0] model_pc;
   logic [15:0] model_ras [$];
   logic        model_of;
   logic        model_uf;

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      num_compared++;
      if (observed !== expected) begin
         num_mismatched++;
         $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Instruction memory: answers each request after a random latency,
   // checks the address stays put while waiting, and if the request vanishes
   // (reset) still fires a stale ack with corrupted data that must be ignored.
   initial begin : memory_responder
      logic [15:0] held_addr;
      int          lat;
      logic        aborted;
      imem_bus.imem_ack  = 1'b0;
      imem_bus.imem_data = '0;
      forever begin
         @(negedge clk);
         imem_bus.imem_ack = 1'b0;
         if (imem_bus.imem_req && rst_n) begin
            held_addr = imem_bus.imem_addr;
            lat       = $urandom_range(lat_max, lat_min);
            aborted   = 1'b0;
            for (int k = 0; k < lat; k++) begin
               @(negedge clk);
               if (!imem_bus.imem_req) begin
                  aborted = 1'b1;
                  break;
               end
               checkOutput("addr_stable", imem_bus.imem_addr, held_addr);
            end
            imem_bus.imem_ack  = 1'b1;
            imem_bus.imem_data = aborted ? ~mem[held_addr] : mem[held_addr];
         end
      end
   end

   task automatic modelReset();
      model_pc = RESET_PC;
      model_ras.delete();
      model_of = 1'b0;
      model_uf = 1'b0;
   endtask

   // Reference next-PC rules applied to a retired instruction.
   task automatic modelRetire(input logic a_inc, input logic a_jump, input logic a_ret,
                              input logic a_call, input logic [15:0] a_jaddr);
      logic [15:0] ret_addr;
      if (a_ret) begin
         if (model_ras.size() == 0) begin
            model_pc = RESET_PC;
            model_uf = 1'b1;
         end else begin
            model_pc = model_ras.pop_back();
         end
      end else if (a_jump) begin
         if (a_call) begin
            ret_addr = model_pc + 16'd1;
            model_ras.push_back(ret_addr);
            if (model_ras.size() > RAS_DEPTH) begin
               void'(model_ras.pop_front());
               model_of = 1'b1;
            end
         end
         model_pc = a_jaddr;
      end else if (a_inc) begin
         model_pc = model_pc + 16'd1;
      end
   endtask

   task automatic clearInputs();
      inst_ready = 1'b0;
      pc_inc     = 1'b0;
      jump       = 1'b0;
      ret        = 1'b0;
      call       = 1'b0;
      jump_addr  = '0;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      clearInputs();
      #1;
      checkOutput("rst_req",       imem_bus.imem_req, 0);
      checkOutput("rst_valid",     inst_valid, 0);
      checkOutput("rst_inst",      instruction, 0);
      checkOutput("rst_pc",        pc, RESET_PC);
      checkOutput("rst_overflow",  ras_overflow, 0);
      checkOutput("rst_underflow", ras_underflow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
   endtask

   // Wait (bounded) for a held instruction, checking the fetch address.
   task automatic waitValid();
      logic got;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (inst_valid) begin
            got = 1'b1;
            break;
         end
         if (imem_bus.imem_req)
            checkOutput("imem_addr", imem_bus.imem_addr, model_pc);
         @(negedge clk);
      end
      if (!got)
         checkOutput("valid_timeout", inst_valid, 1);
   endtask

   // Retire the held instruction with the given next-PC decision.
   task automatic applyStimulus(input logic a_inc, input logic a_jump, input logic a_ret,
                                input logic a_call, input logic [15:0] a_jaddr);
      pc_inc     = a_inc;
      jump       = a_jump;
      ret        = a_ret;
      call       = a_call;
      jump_addr  = a_jaddr;
      inst_ready = 1'b1;
      @(posedge clk);
      modelRetire(a_inc, a_jump, a_ret, a_call, a_jaddr);
      @(negedge clk);
      clearInputs();
      checkOutput("valid_drop", inst_valid, 0);
   endtask

   // One full instruction: wait, check what decode sees, optionally stall
   // with junk next-PC inputs, then retire.
   task automatic stepInstr(input logic a_inc, input logic a_jump, input logic a_ret,
                            input logic a_call, input logic [15:0] a_jaddr, input int stall);
      waitValid();
      checkOutput("instruction", instruction, mem[model_pc]);
      checkOutput("pc",          pc, model_pc);
      checkOutput("overflow",    ras_overflow, model_of);
      checkOutput("underflow",   ras_underflow, model_uf);
      for (int s = 0; s < stall; s++) begin
         pc_inc     = 1'($urandom_range(1));
         jump       = 1'($urandom_range(1));
         ret        = 1'($urandom_range(1));
         call       = 1'($urandom_range(1));
         jump_addr  = 16'($urandom);
         inst_ready = 1'b0;
         @(negedge clk);
         checkOutput("stall_valid", inst_valid, 1);
         checkOutput("stall_inst",  instruction, mem[model_pc]);
         checkOutput("stall_pc",    pc, model_pc);
      end
      applyStimulus(a_inc, a_jump, a_ret, a_call, a_jaddr);
   endtask

   initial begin : main
      logic r_inc, r_jump, r_ret, r_call;
      for (int a = 0; a < 65536; a++)
         mem[a] = 18'($urandom);
      rst_n = 1'b0;
      clearInputs();
      modelReset();

      // Reset and first fetch with an immediate ack.
      lat_min = 0;
      lat_max = 0;
      doReset();
      @(negedge clk);
      checkOutput("first_req",  imem_bus.imem_req, 1);
      checkOutput("first_addr", imem_bus.imem_addr, 16'h0000);
      @(negedge clk);
      checkOutput("first_valid", inst_valid, 1);
      checkOutput("first_pc",    pc, 16'h0000);
      stepInstr(1, 0, 0, 0, 16'h0, 0);

      // Sequential fetches with a 3-cycle memory wait.
      lat_min = 3;
      lat_max = 3;
      for (int i = 0; i < 3; i++)
         stepInstr(1, 0, 0, 0, 16'h0, 0);

      // PC wrap from FFFF to 0000.
      lat_min = 0;
      lat_max = 2;
      stepInstr(0, 1, 0, 0, 16'hFFFF, 0);
      stepInstr(1, 0, 0, 0, 16'h0, 0);

      // CALL at 0010 to 0200, RET back to 0011, then 3-deep nesting.
      stepInstr(0, 1, 0, 0, 16'h0010, 0);
      stepInstr(0, 1, 0, 1, 16'h0200, 0);
      stepInstr(1, 0, 0, 0, 16'h0, 0);
      stepInstr(0, 0, 1, 0, 16'h0, 0);
      checkOutput("ret_target", pc, 16'h0011);
      stepInstr(0, 1, 0, 1, 16'h0300, 0);
      stepInstr(0, 1, 0, 1, 16'h0400, 0);
      stepInstr(0, 1, 0, 1, 16'h0500, 0);
      for (int i = 0; i < 3; i++)
         stepInstr(0, 0, 1, 0, 16'h0, 0);

      // Five-cycle decode stall, then ret+jump+call together (pop wins).
      stepInstr(1, 0, 0, 0, 16'h0, 5);
      stepInstr(0, 1, 0, 1, 16'h0700, 0);
      stepInstr(0, 1, 1, 1, 16'h0900, 0);
      stepInstr(0, 0, 1, 0, 16'h0, 0);

      // RAS_DEPTH+1 calls lose the oldest return; the last ret underflows.
      doReset();
      for (int i = 0; i <= RAS_DEPTH; i++)
         stepInstr(0, 1, 0, 1, 16'h1000 + 16'(i * 16), 0);
      for (int i = 0; i <= RAS_DEPTH; i++)
         stepInstr(0, 0, 1, 0, 16'h0, 0);
      stepInstr(1, 0, 0, 0, 16'h0, 0);

      // Reset pulsed while a slow fetch is outstanding.
      lat_min = 5;
      lat_max = 5;
      stepInstr(0, 1, 0, 0, 16'h2345, 0);
      @(negedge clk);
      doReset();
      lat_min = 0;
      lat_max = 3;
      stepInstr(1, 0, 0, 0, 16'h0, 0);
      checkOutput("post_abort_pc", pc, 16'h0001);

      // Random decode decisions, latencies and stalls.
      for (int n = 0; n < 200; n++) begin
         r_ret  = ($urandom_range(99) < 12);
         r_jump = ($urandom_range(99) < 30);
         r_inc  = ($urandom_range(99) < 80);
         r_call = 1'($urandom_range(1));
         stepInstr(r_inc, r_jump, r_ret, r_call, {2'b00, 14'($urandom)},
                   int'($urandom_range(2)));
      end
      waitValid();
      checkOutput("final_pc", pc, model_pc);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
      $finish;
   end
endmodule
